// File: rtl/serial_sub.sv
// serial_sub: digit-serial subtractor (Result = in1 - in2) with borrow/ovf/zero flags, optional slt via SERIAL_SUB_SLT_EN
module serial_sub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
`ifdef SERIAL_SUB_SLT_EN
  ,
  output logic             slt
`endif
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_sub: DIGIT must divide WIDTH");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic brw_q, brw_d, borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;
`ifdef SERIAL_SUB_SLT_EN
  logic slt_q, slt_d;
  assign slt = slt_q;
`endif
  logic [DIGIT:0] diff;
  logic last;
  assign diff = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};
  assign last = cnt_q == CW'(NDIG - 1);
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign Result = res_q;
  assign borrow = borrow_q;
  assign ovf = ovf_q;
  assign zero = zero_q;
  // a_q doubles as the result shift register: consumed minuend digits leave at the
  // bottom while difference digits enter at the top, so after the last digit the
  // low digit of a_q/b_q still held the original sign bits when they were used.
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    brw_d = brw_q;
    res_d = res_q;
    borrow_d = borrow_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
`ifdef SERIAL_SUB_SLT_EN
    slt_d = slt_q;
`endif
    if (state_q == RUN) begin
      a_d = WIDTH'({diff[DIGIT-1:0], a_q} >> DIGIT);
      b_d = b_q >> DIGIT;
      brw_d = diff[DIGIT];
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = DONE;
        res_d = a_d;
        borrow_d = diff[DIGIT];
        ovf_d = (a_q[DIGIT-1] != b_q[DIGIT-1]) && (diff[DIGIT-1] != a_q[DIGIT-1]);
        zero_d = a_d == '0;
`ifdef SERIAL_SUB_SLT_EN
        slt_d = diff[DIGIT-1] ^ ovf_d;
`endif
      end
    end else begin
      state_d = start ? RUN : IDLE;
      if (start) begin
        a_d = in1;
        b_d = in2;
        cnt_d = '0;
        brw_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      brw_q <= 1'b0;
      res_q <= '0;
      borrow_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
`ifdef SERIAL_SUB_SLT_EN
      slt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      brw_q <= brw_d;
      res_q <= res_d;
      borrow_q <= borrow_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
`ifdef SERIAL_SUB_SLT_EN
      slt_q <= slt_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub with default WIDTH=32, DIGIT=4
module tb_serial_sub;
  localparam int NDIG = 8;
  typedef struct packed {
    logic [31:0] r;
    logic b;
    logic o;
    logic z;
    logic s;
  } exp_t;
  logic clk = 0, reset, start;
  logic [31:0] in1, in2, Result;
  logic busy, done, borrow, ovf, zero;
`ifdef SERIAL_SUB_SLT_EN
  logic slt;
`endif
  exp_t sb[$];
  int n_tests = 0, n_fail = 0;
  serial_sub dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in1(in1),
    .in2(in2),
    .busy(busy),
    .done(done),
    .Result(Result),
    .borrow(borrow),
    .ovf(ovf),
    .zero(zero)
`ifdef SERIAL_SUB_SLT_EN
    ,
    .slt(slt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.r = a - b;
    e.b = a < b;
    e.o = (a[31] != b[31]) && (e.r[31] != a[31]);
    e.z = e.r == 0;
    e.s = $signed(a) < $signed(b);
    return e;
  endfunction
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb.size() == 0) check("spurious_done", 32'(sb.size()), 1);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("result", Result, e.r);
        check("borrow", borrow, e.b);
        check("ovf", ovf, e.o);
        check("zero", zero, e.z);
`ifdef SERIAL_SUB_SLT_EN
        check("slt", slt, e.s);
`endif
      end
    end
  end
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
    in1 = a;
    in2 = b;
    start = 1;
    if (push) sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 0;
    check("busy_on", busy, 1);
  endtask
  task automatic wait_done(input int exp_n);
    int n = 0;
    int nb = busy;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) nb++;
    end
    check("latency", n, exp_n);
    check("busy_cycles", nb, exp_n);
  endtask
  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result"}, Result, 0);
    check({tag, "_flags"}, {borrow, ovf, zero}, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    reset = 1;
    start = 1;
    in1 = 32'd7;
    in2 = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    start = 0;
    reset = 0;
    start_op(32'd6, 32'd2, 1);
    wait_done(NDIG);
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
    start_op(32'd5, 32'd9, 1);
    wait_done(NDIG);
    start_op(32'h8000_0000, 32'd1, 1);
    wait_done(NDIG);
    start_op(32'd10, 32'd10, 1);
    wait_done(NDIG);
    start_op(32'd10, 32'd6, 1);
    wait_done(NDIG);
    start_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_done(NDIG);
    for (int i = 0; i < 4; i++) begin
      start_op($urandom, $urandom, 1);
      wait_done(NDIG);
    end
    start_op(32'd2, 32'd3, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    in1 = 32'd1;
    in2 = 32'd3;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    wait_done(NDIG - 3);
    check("hold_result", Result, 32'hFFFF_FFFF);
    start_op(32'd5, 32'd9, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    check_cleared("abort");
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    check("abort_idle", busy, 0);
    start_op(32'd100, 32'd1, 1);
    wait_done(NDIG);
    @(posedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
